// File: rtl/dcache_pkg.sv
// Shared constants for the data-cache controller: geometry, SRAM tag-word
// field positions and the FSM state encoding.
package dcache_pkg;

    localparam int ADDR_W    = 32;
    localparam int INDEX_W   = 4;
    localparam int TAG_W     = 23;
    localparam int LINE_W    = 256;
    localparam int WORD_W    = 32;
    localparam int TAGWORD_W = TAG_W + 2;

    // SRAM tag word layout: {valid, dirty, tag[22:0]}
    localparam int TAG_VALID_BIT = 24;
    localparam int TAG_DIRTY_BIT = 23;

    localparam int OFFSET_W     = 5;
    localparam int WORD_SEL_MSB = 4;
    localparam int WORD_SEL_LSB = 2;
    localparam int WORD_SEL_W   = WORD_SEL_MSB - WORD_SEL_LSB + 1;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_MISS       = 3'd1;
    localparam logic [2:0] ST_WRITEBACK  = 3'd2;
    localparam logic [2:0] ST_READMISS   = 3'd3;
    localparam logic [2:0] ST_READMISSOK = 3'd4;

endpackage

// File: rtl/dcache_controller_if.sv
// CPU, main-memory and SRAM signals of the cache controller. The slave
// modport is the controller's view; master is the surrounding system's view.
interface dcache_controller_if;
    import dcache_pkg::*;

    // Memory handshake: mem_enable_o is a level request; mem_write_o and
    // mem_addr_o hold steady until mem_ack_i pulses for exactly one cycle.
    logic [ADDR_W-1:0]     cpu_addr_i;
    logic [WORD_W-1:0]     cpu_data_i;
    logic                  cpu_MemRead_i;
    logic                  cpu_MemWrite_i;
    logic [WORD_W-1:0]     cpu_data_o;
    logic                  cpu_stall_o;

    logic [ADDR_W-1:0]     mem_addr_o;
    logic [LINE_W-1:0]     mem_data_o;
    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [LINE_W-1:0]     mem_data_i;
    logic                  mem_ack_i;

    logic [INDEX_W-1:0]    sram_addr_o;
    logic [TAGWORD_W-1:0]  sram_tag_o;
    logic [LINE_W-1:0]     sram_data_o;
    logic                  sram_enable_o;
    logic                  sram_write_o;
    logic [TAGWORD_W-1:0]  sram_tag_i;
    logic [LINE_W-1:0]     sram_data_i;
    logic                  sram_hit_i;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output cpu_data_o, cpu_stall_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        input  mem_data_i, mem_ack_i,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        input  sram_tag_i, sram_data_i, sram_hit_i
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        output mem_data_i, mem_ack_i,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        output sram_tag_i, sram_data_i, sram_hit_i
    );

endinterface

// File: rtl/dcache_word_mux.sv
// Selects one 32-bit word out of a cache line and builds the same line with
// that word replaced by new store data.
module dcache_word_mux
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0]     line_i,
    input  logic [WORD_SEL_W-1:0] sel_i,
    input  logic [WORD_W-1:0]     word_i,
    output logic [WORD_W-1:0]     word_o,
    output logic [LINE_W-1:0]     line_o
);

    assign word_o = line_i[sel_i*WORD_W +: WORD_W];

    always_comb begin
        line_o = line_i;
        line_o[sel_i*WORD_W +: WORD_W] = word_i;
    end

endmodule

// File: rtl/dcache_controller.sv
// Miss-handling controller for the 2-way data cache: serves hits in place,
// writes back a dirty victim, refills from memory and replays the access.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_controller_if.slave  bus,
    output logic [2:0]          state_o
);

    logic [2:0]        state_q, state_d;
    logic [TAG_W-1:0]  victim_tag_q, victim_tag_d;
    logic [LINE_W-1:0] victim_line_q, victim_line_d;
    logic [LINE_W-1:0] refill_q, refill_d;

    logic                  req;
    logic [TAG_W-1:0]      cpu_tag;
    logic [INDEX_W-1:0]    cpu_index;
    logic [WORD_SEL_W-1:0] word_sel;
    logic [WORD_W-1:0]     hit_word;
    logic [LINE_W-1:0]     merged_line;
    logic                  unused_byte_bits;

    assign req       = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign cpu_tag   = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_index = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
    assign word_sel  = bus.cpu_addr_i[WORD_SEL_MSB:WORD_SEL_LSB];
    assign unused_byte_bits = ^bus.cpu_addr_i[WORD_SEL_LSB-1:0];
    assign state_o   = state_q;

    dcache_word_mux u_word_mux (
        .line_i (bus.sram_data_i),
        .sel_i  (word_sel),
        .word_i (bus.cpu_data_i),
        .word_o (hit_word),
        .line_o (merged_line)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            victim_tag_q  <= '0;
            victim_line_q <= '0;
            refill_q      <= '0;
        end else begin
            state_q       <= state_d;
            victim_tag_q  <= victim_tag_d;
            victim_line_q <= victim_line_d;
            refill_q      <= refill_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        victim_tag_d  = victim_tag_q;
        victim_line_d = victim_line_q;
        refill_d      = refill_q;
        case (state_q)
            ST_IDLE: begin
                if (req && !bus.sram_hit_i) state_d = ST_MISS;
            end
            ST_MISS: begin
                // The SRAM presents the LRU way on a miss; that is the victim.
                victim_tag_d  = bus.sram_tag_i[TAG_W-1:0];
                victim_line_d = bus.sram_data_i;
                if (bus.sram_tag_i[TAG_VALID_BIT] && bus.sram_tag_i[TAG_DIRTY_BIT])
                    state_d = ST_WRITEBACK;
                else
                    state_d = ST_READMISS;
            end
            ST_WRITEBACK: begin
                if (bus.mem_ack_i) state_d = ST_READMISS;
            end
            ST_READMISS: begin
                if (bus.mem_ack_i) begin
                    refill_d = bus.mem_data_i;
                    state_d  = ST_READMISSOK;
                end
            end
            ST_READMISSOK: state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_stall_o   = (state_q == ST_IDLE) ? (req & ~bus.sram_hit_i) : 1'b1;
        bus.cpu_data_o    = bus.sram_hit_i ? hit_word : '0;
        // The refill write must land even if the request vanished mid-miss.
        bus.sram_enable_o = req | (state_q == ST_READMISSOK);
        bus.sram_addr_o   = cpu_index;
        bus.sram_write_o  = 1'b0;
        bus.sram_tag_o    = {2'b00, cpu_tag};
        bus.sram_data_o   = '0;
        bus.mem_enable_o  = 1'b0;
        bus.mem_write_o   = 1'b0;
        bus.mem_addr_o    = '0;
        bus.mem_data_o    = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_MemWrite_i && bus.sram_hit_i) begin
                    bus.sram_write_o = 1'b1;
                    bus.sram_tag_o   = {2'b11, cpu_tag};
                    bus.sram_data_o  = merged_line;
                end
            end
            ST_WRITEBACK: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {victim_tag_q, cpu_index, {OFFSET_W{1'b0}}};
                bus.mem_data_o   = victim_line_q;
            end
            ST_READMISS: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};
            end
            ST_READMISSOK: begin
                bus.sram_write_o = 1'b1;
                bus.sram_tag_o   = {2'b10, cpu_tag};
                bus.sram_data_o  = refill_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a small 2-way LRU SRAM model
// and hand-driven memory acknowledgements.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt = 0;
  bit cnt_en = 1'b0;
  logic [31:0] exp_q[$];

  dcache_controller_if bus();

  dcache_controller dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk_i) if (cnt_en && bus.cpu_stall_o) stall_cnt++;

  // ---------------- 2-way LRU SRAM model ----------------
  logic [24:0]  tag_mem  [2][16];
  logic [255:0] data_mem [2][16];
  logic         lru      [16];
  logic         h0, h1, sel_way;

  always_comb begin
    h0 = tag_mem[0][bus.sram_addr_o][24] && (tag_mem[0][bus.sram_addr_o][22:0] == bus.sram_tag_o[22:0]);
    h1 = tag_mem[1][bus.sram_addr_o][24] && (tag_mem[1][bus.sram_addr_o][22:0] == bus.sram_tag_o[22:0]);
    sel_way = h0 ? 1'b0 : (h1 ? 1'b1 : lru[bus.sram_addr_o]);
    bus.sram_hit_i  = bus.sram_enable_o & (h0 | h1);
    bus.sram_tag_i  = tag_mem[sel_way][bus.sram_addr_o];
    bus.sram_data_i = data_mem[sel_way][bus.sram_addr_o];
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 16; s++) begin
          tag_mem[w][s]  <= '0;
          data_mem[w][s] <= '0;
        end
      for (int s = 0; s < 16; s++) lru[s] <= 1'b0;
    end else if (bus.sram_enable_o) begin
      if (bus.sram_write_o) begin
        tag_mem[sel_way][bus.sram_addr_o]  <= bus.sram_tag_o;
        data_mem[sel_way][bus.sram_addr_o] <= bus.sram_data_o;
        lru[bus.sram_addr_o] <= ~sel_way;
      end else if (bus.sram_hit_i) begin
        lru[bus.sram_addr_o] <= ~sel_way;
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
    return l;
  endfunction

  function automatic logic [255:0] set_word(input logic [255:0] l, input int idx, input logic [31:0] w);
    logic [255:0] r;
    r = l;
    r[idx*32 +: 32] = w;
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [31:0] addr, input bit wr, input logic [31:0] wdata);
    bus.cpu_addr_i     = addr;
    bus.cpu_data_i     = wdata;
    bus.cpu_MemRead_i  = !wr;
    bus.cpu_MemWrite_i = wr;
    #1;
  endtask

  task automatic drop_req();
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
  endtask

  // Full miss sequence: optional writeback taking k_wb cycles, refill taking k_rm.
  task automatic run_miss(input string nm, input logic [31:0] addr, input bit wr,
                          input logic [31:0] wdata, input bit wb, input logic [31:0] wb_addr,
                          input logic [255:0] wb_line, input int k_wb, input int k_rm,
                          input logic [255:0] refill, input logic [31:0] rd_word,
                          input int exp_stall);
    logic [31:0] rm_addr;
    rm_addr = {addr[31:5], 5'b0};
    stall_cnt = 0;
    cnt_en = 1'b1;
    drive_req(addr, wr, wdata);
    check({nm, "_first_stall"}, bus.cpu_stall_o, 1);
    check({nm, "_miss_data0"}, bus.cpu_data_o, 0);
    tick();
    check({nm, "_state_miss"}, state_o, ST_MISS);
    tick();
    if (wb) begin
      check({nm, "_state_wb"}, state_o, ST_WRITEBACK);
      check({nm, "_wb_en"}, bus.mem_enable_o, 1);
      check({nm, "_wb_wr"}, bus.mem_write_o, 1);
      check({nm, "_wb_addr"}, bus.mem_addr_o, wb_addr);
      check({nm, "_wb_data"}, bus.mem_data_o, wb_line);
      repeat (k_wb - 1) tick();
      check({nm, "_wb_addr_held"}, bus.mem_addr_o, wb_addr);
      bus.mem_ack_i = 1'b1;
      tick();
      bus.mem_ack_i = 1'b0;
    end
    check({nm, "_state_rm"}, state_o, ST_READMISS);
    check({nm, "_rm_en"}, bus.mem_enable_o, 1);
    check({nm, "_rm_wr"}, bus.mem_write_o, 0);
    check({nm, "_rm_addr"}, bus.mem_addr_o, rm_addr);
    repeat (k_rm - 1) tick();
    check({nm, "_rm_addr_held"}, bus.mem_addr_o, rm_addr);
    bus.mem_data_i = refill;
    bus.mem_ack_i  = 1'b1;
    tick();
    bus.mem_ack_i  = 1'b0;
    #1;
    check({nm, "_state_rmok"}, state_o, ST_READMISSOK);
    check({nm, "_fill_wr"}, bus.sram_write_o, 1);
    check({nm, "_fill_tag"}, bus.sram_tag_o, {2'b10, addr[31:9]});
    check({nm, "_fill_data"}, bus.sram_data_o, refill);
    check({nm, "_en_dropped"}, bus.mem_enable_o, 0);
    tick();
    cnt_en = 1'b0;
    check({nm, "_state_idle"}, state_o, ST_IDLE);
    check({nm, "_replay_stall"}, bus.cpu_stall_o, 0);
    if (wr) begin
      check({nm, "_replay_wr"}, bus.sram_write_o, 1);
      check({nm, "_replay_tag"}, bus.sram_tag_o, {2'b11, addr[31:9]});
      check({nm, "_replay_line"}, bus.sram_data_o, set_word(refill, int'(addr[4:2]), wdata));
    end else begin
      exp_q.push_back(rd_word);
      check({nm, "_replay_data"}, bus.cpu_data_o, exp_q.pop_front());
    end
    check({nm, "_stall_cycles"}, stall_cnt, exp_stall);
    tick();
    drop_req();
    bus.mem_data_i = '0;
  endtask

  task automatic hit_read(input string nm, input logic [31:0] addr, input logic [31:0] exp_word);
    drive_req(addr, 1'b0, 32'h0);
    exp_q.push_back(exp_word);
    check({nm, "_stall"}, bus.cpu_stall_o, 0);
    check({nm, "_data"}, bus.cpu_data_o, exp_q.pop_front());
    tick();
    drop_req();
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] l1, l2, l3, l4, l5, l1_dirty;

  initial begin
    l1 = set_word(make_line(32'hA000_0000), 1, 32'hDEAD_BEEF);
    l2 = make_line(32'hB000_0000);
    l3 = make_line(32'hC000_0000);
    l4 = make_line(32'hD000_0000);
    l5 = make_line(32'hE000_0000);
    l1_dirty = set_word(l1, 2, 32'h1234_5678);

    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    bus.cpu_MemRead_i = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    bus.mem_data_i = '0;
    bus.mem_ack_i = 1'b1;

    // Reset with a stray ack present
    rst_i = 1'b0;
    repeat (2) tick();
    check("rst_state", state_o, ST_IDLE);
    check("rst_mem_en", bus.mem_enable_o, 0);
    check("rst_mem_wr", bus.mem_write_o, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_stall", bus.cpu_stall_o, 0);
    bus.mem_ack_i = 1'b0;
    rst_i = 1'b1;
    tick();

    // Cold read, ack after 10 cycles of READMISS
    run_miss("cold_rd", 32'h0000_0044, 1'b0, 32'h0, 1'b0, 32'h0, '0, 0, 10, l1, 32'hDEAD_BEEF, 13);

    // Store hit: same-cycle write, dirty tag, merged line
    drive_req(32'h0000_0048, 1'b1, 32'h1234_5678);
    check("st_hit_stall", bus.cpu_stall_o, 0);
    check("st_hit_wr", bus.sram_write_o, 1);
    check("st_hit_tag", bus.sram_tag_o, 25'h180_0000);
    check("st_hit_line", bus.sram_data_o, l1_dirty);
    tick();
    drop_req();
    hit_read("ld_after_st", 32'h0000_0048, 32'h1234_5678);
    hit_read("ld_word1", 32'h0000_0044, 32'hDEAD_BEEF);

    // Clean fill of the second way of set 2, then a dirty eviction
    run_miss("clean_240", 32'h0000_0240, 1'b0, 32'h0, 1'b0, 32'h0, '0, 0, 4, l2, 32'hB000_0000, 7);
    run_miss("dirty_440", 32'h0000_0440, 1'b0, 32'h0, 1'b1, 32'h0000_0040, l1_dirty, 3, 2, l3, 32'hC000_0000, 8);

    // Reset during READMISS, then a late ack
    drive_req(32'h0000_0800, 1'b0, 32'h0);
    tick();
    tick();
    check("rst5_in_rm", state_o, ST_READMISS);
    check("rst5_rm_en", bus.mem_enable_o, 1);
    check("rst5_rm_addr", bus.mem_addr_o, 32'h0000_0800);
    rst_i = 1'b0;
    drop_req();
    tick();
    rst_i = 1'b1;
    check("rst5_state", state_o, ST_IDLE);
    check("rst5_mem_en", bus.mem_enable_o, 0);
    check("rst5_mem_addr", bus.mem_addr_o, 0);
    check("rst5_stall", bus.cpu_stall_o, 0);
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    check("late_ack_state", state_o, ST_IDLE);
    check("late_ack_mem_en", bus.mem_enable_o, 0);

    // Ack in the first READMISS cycle: 4 stall cycles
    run_miss("k1_rd", 32'h0000_0C04, 1'b0, 32'h0, 1'b0, 32'h0, '0, 0, 1, l4, 32'hD000_0001, 4);

    // Store miss: refill then merge on the replay cycle
    run_miss("st_miss", 32'h0000_1008, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, '0, 0, 2, l5, 32'h0, 5);
    hit_read("ld_st_miss", 32'h0000_1008, 32'hCAFE_F00D);
    hit_read("ld_other_way", 32'h0000_0C04, 32'hD000_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
